// File: rtl/led_scan_scheduler.sv
// Dual 8x8 LED matrix scan controller: double-buffered frames, 16-slot X/Y
// interleaved column scan on a shared row bus, with optional blanking between slots.
module led_scan_scheduler #(
  parameter int DWELL = 16384,
  parameter int BLANK = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        new_valid,
  input  logic [71:0] new_x,
  input  logic [71:0] new_y,
  output logic [7:0]  row,
  output logic [7:0]  colx,
  output logic [7:0]  coly,
  output logic        frame_start,
  output logic        swap_done,
  output logic        pending
);

  localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam bit HAS_BLANK = (BLANK > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [3:0]      slot, slot_n;
  logic [TW-1:0]   tick, tick_n;
  logic [143:0]    active_buf;
  logic [143:0]    shadow_buf;
  logic            swap;

  // Next-state logic. A swap happens only when the scan wraps from slot 15
  // to slot 0, or while idling, so a displayed frame is never torn.
  always_comb begin
    state_n = state;
    slot_n  = slot;
    tick_n  = tick;
    swap    = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      slot_n  = 4'd0;
      tick_n  = '0;
      swap    = (state == ST_IDLE) && pending;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_ON;
          slot_n  = 4'd0;
          tick_n  = '0;
          swap    = pending;
        end
        ST_ON: begin
          if (tick == DWELL_LAST) begin
            tick_n = '0;
            if (HAS_BLANK) begin
              state_n = ST_BLANK;
            end else begin
              slot_n = slot + 4'd1;
              swap   = (slot == 4'd15);
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
        ST_BLANK: begin
          if (tick == BLANK_LAST) begin
            tick_n  = '0;
            state_n = ST_ON;
            slot_n  = slot + 4'd1;
            swap    = (slot == 4'd15);
          end else begin
            tick_n = tick + TW'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          slot_n  = 4'd0;
          tick_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      slot       <= 4'd0;
      tick       <= '0;
      active_buf <= '0;
      shadow_buf <= '0;
      pending    <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      tick      <= tick_n;
      swap_done <= swap;
      if (swap) begin
        active_buf <= shadow_buf;
      end
      // A strobe coinciding with a swap lands in the shadow after the old
      // shadow has been consumed, so pending stays set.
      if (new_valid) begin
        shadow_buf <= {new_x, new_y};
        pending    <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
    end
  end

  logic [71:0] frame_sel;
  logic [2:0]  col_idx;
  logic        panel;
  logic [5:0]  row_base;
  logic [7:0]  col_onehot;

  // Moore output decode straight from the state registers.
  always_comb begin
    panel       = slot[0];
    col_idx     = slot[3:1];
    frame_sel   = panel ? active_buf[71:0] : active_buf[143:72];
    row_base    = {~col_idx, 3'b111};
    col_onehot  = frame_sel[7'd64 + {4'd0, col_idx}] ? (8'd1 << col_idx) : 8'd0;
    row         = 8'd0;
    colx        = 8'd0;
    coly        = 8'd0;
    frame_start = 1'b0;
    if (state == ST_ON) begin
      row         = frame_sel[row_base -: 8];
      frame_start = (slot == 4'd0) && (tick == '0);
      if (panel) begin
        coly = col_onehot;
      end else begin
        colx = col_onehot;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Randomized scoreboard bench for led_scan_scheduler: two instances (with and
// without blanking) checked every cycle against a timeline-based reference model.
module tb_led_scan_scheduler;

  localparam int D0 = 4;
  localparam int B0 = 2;
  localparam int D1 = 3;
  localparam int B1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        enable;
  logic        new_valid;
  logic [71:0] new_x;
  logic [71:0] new_y;

  logic [7:0] row0, colx0, coly0, row1, colx1, coly1;
  logic       fs0, sd0, pend0, fs1, sd1, pend1;

  led_scan_scheduler #(.DWELL(D0), .BLANK(B0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .new_valid(new_valid),
    .new_x(new_x), .new_y(new_y), .row(row0), .colx(colx0), .coly(coly0),
    .frame_start(fs0), .swap_done(sd0), .pending(pend0)
  );

  led_scan_scheduler #(.DWELL(D1), .BLANK(B1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .new_valid(new_valid),
    .new_x(new_x), .new_y(new_y), .row(row1), .colx(colx1), .coly(coly1),
    .frame_start(fs1), .swap_done(sd1), .pending(pend1)
  );

  int checks = 0;
  int errors = 0;

  // expected {row, colx, coly, frame_start, swap_done, pending}
  logic [26:0] exp_q0[$];
  logic [26:0] exp_q1[$];

  // Reference model: a running scan is just a cycle count t since the scan
  // started; slot and phase fall out of t by division.
  bit           m_run[2];
  int           m_t[2];
  logic [143:0] m_act[2];
  logic [143:0] m_shd[2];
  bit           m_pend[2];

  task automatic model_step(input int i, input int d, input int b, output logic [26:0] e);
    bit sw;
    int per, p, s, w, c;
    logic [71:0] frm;
    logic [7:0] r, cx, cy;
    bit fs;
    sw = 0;
    per = 16 * (d + b);
    if (reset) begin
      m_run[i] = 0; m_t[i] = 0; m_act[i] = '0; m_shd[i] = '0; m_pend[i] = 0;
    end else begin
      if (!m_run[i]) begin
        sw = m_pend[i];
        if (enable) begin m_run[i] = 1; m_t[i] = 0; end
      end else if (!enable) begin
        m_run[i] = 0;
      end else begin
        m_t[i]++;
        if (m_t[i] % per == 0) sw = 1;
      end
      if (sw) begin m_act[i] = m_shd[i]; m_pend[i] = 0; end
      if (new_valid) begin m_shd[i] = {new_x, new_y}; m_pend[i] = 1; end
    end
    r = 0; cx = 0; cy = 0; fs = 0;
    if (m_run[i]) begin
      p = m_t[i] % per;
      s = p / (d + b);
      w = p % (d + b);
      fs = (p == 0);
      if (w < d) begin
        c = s / 2;
        frm = (s % 2 == 1) ? m_act[i][71:0] : m_act[i][143:72];
        r = frm[63 - 8*c -: 8];
        if (frm[64 + c]) begin
          if (s % 2 == 1) cy = 8'(1 << c);
          else            cx = 8'(1 << c);
        end
      end
    end
    e = {r, cx, cy, fs, sw, m_pend[i]};
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input int i, input logic [26:0] e);
    if (i == 0) begin
      check("row0", row0, e[26:19]);   check("colx0", colx0, e[18:11]);
      check("coly0", coly0, e[10:3]);  check("frame_start0", 8'(fs0), 8'(e[2]));
      check("swap_done0", 8'(sd0), 8'(e[1])); check("pending0", 8'(pend0), 8'(e[0]));
    end else begin
      check("row1", row1, e[26:19]);   check("colx1", colx1, e[18:11]);
      check("coly1", coly1, e[10:3]);  check("frame_start1", 8'(fs1), 8'(e[2]));
      check("swap_done1", 8'(sd1), 8'(e[1])); check("pending1", 8'(pend1), 8'(e[0]));
    end
  endtask

  // Monitor: sample just after each active edge and retire one expectation per instance.
  always @(posedge clk) begin
    logic [26:0] e;
    #1;
    if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); compare(0, e); end
    if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); compare(1, e); end
  end

  // Drive one cycle of inputs at the falling edge and queue the model's response.
  task automatic drive(input logic rst, input logic en, input logic nv,
                       input logic [71:0] x, input logic [71:0] y);
    logic [26:0] e;
    @(negedge clk);
    reset = rst; enable = en; new_valid = nv; new_x = x; new_y = y;
    model_step(0, D0, B0, e); exp_q0.push_back(e);
    model_step(1, D1, B1, e); exp_q1.push_back(e);
  endtask

  function automatic logic [71:0] rnd72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    logic [71:0] pat_x;
    logic [71:0] x, y;
    logic en, nv, rst;
    int off_cnt;
    reset = 1'b1; enable = 1'b0; new_valid = 1'b0; new_x = '0; new_y = '0;
    pat_x = '0;
    pat_x[71:64] = 8'hFF;
    for (int c = 0; c < 8; c++) pat_x[63 - 8*c -: 8] = 8'(1 << c);

    for (int k = 0; k < 3; k++) drive(1, 0, 0, '0, '0);
    // blank frame scanning: all outputs dark, frame_start every period
    for (int k = 0; k < 200; k++) drive(0, 1, 0, '0, '0);
    // load the diagonal X pattern while idle, then scan it
    drive(0, 0, 1, pat_x, '0);
    drive(0, 0, 0, '0, '0);
    for (int k = 0; k < 250; k++) drive(0, 1, 0, '0, '0);
    // mask restricted to column 2 of X
    x = pat_x; x[71:64] = 8'h04;
    drive(0, 1, 1, x, rnd72());
    for (int k = 0; k < 200; k++) drive(0, 1, 0, '0, '0);

    off_cnt = 0;
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 999) == 0);
      if (off_cnt > 0) off_cnt--;
      else if ($urandom_range(0, 199) == 0) off_cnt = $urandom_range(1, 6);
      en = (off_cnt == 0);
      nv = ($urandom_range(0, 49) == 0);
      // aim a strobe at the wrap cycle of the blanking instance
      if (en && !rst && m_run[0] && ((m_t[0] + 1) % (16 * (D0 + B0)) == 0) &&
          $urandom_range(0, 1) == 1)
        nv = 1;
      x = rnd72(); y = rnd72();
      drive(rst, en, nv, x, y);
    end
    drive(0, 1, 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q0.size() + exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
